// File: rtl/stack_access_ctrl.sv
// Hardware-stack access sequencer: orders SP strobes and scratch RAM accesses for push/pop/load.
// Optional depth high-water mark output enabled by defining STACK_WATERMARK_EN.
module stack_access_ctrl #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  input  logic [1:0]        REQ_OP,
  input  logic [DATA_W-1:0] REQ_DATA,
  output logic              REQ_READY,
  output logic              RSP_VALID,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              RSP_ERR,
  input  logic [ADDR_W-1:0] SP_IN,
  output logic              SP_LD,
  output logic              SP_INCR,
  output logic              SP_DECR,
  output logic [ADDR_W-1:0] SP_DATA_OUT,
  output logic [ADDR_W-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [DATA_W-1:0] SCR_WDATA,
  input  logic [DATA_W-1:0] SCR_RDATA,
  output logic [ADDR_W:0]   DEPTH,
  output logic              FULL,
  output logic              EMPTY
`ifdef STACK_WATERMARK_EN
  ,
  output logic [ADDR_W:0]   MAX_DEPTH
`endif
);

  localparam int unsigned DEPTH_W  = ADDR_W + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP_RD,
    S_POP_CAP,
    S_LOAD,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_LOAD = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic                sp_ld_q;
  logic                sp_incr_q;
  logic                sp_decr_q;
  logic [ADDR_W-1:0]   sp_data_q;
  logic [ADDR_W-1:0]   scr_addr_q;
  logic                scr_we_q;
  logic [DATA_W-1:0]   scr_wdata_q;
  logic [DEPTH_W-1:0]  depth_q;
  logic [DEPTH_W-1:0]  depth_inc_c;
  logic [DEPTH_W-1:0]  depth_dec_c;
  logic                full_c;
  logic                empty_c;
`ifdef STACK_WATERMARK_EN
  logic [DEPTH_W-1:0]  max_depth_q;
`endif

  assign depth_inc_c = depth_q + DEPTH_W'(1);
  assign depth_dec_c = depth_q - DEPTH_W'(1);
  assign full_c      = (depth_q == DEPTH_W'(CAPACITY));
  assign empty_c     = (depth_q == '0);

  // Outputs are registered one edge ahead so each strobe lines up with its state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      sp_ld_q     <= 1'b0;
      sp_incr_q   <= 1'b0;
      sp_decr_q   <= 1'b0;
      sp_data_q   <= '0;
      scr_addr_q  <= '0;
      scr_we_q    <= 1'b0;
      scr_wdata_q <= '0;
      depth_q     <= '0;
`ifdef STACK_WATERMARK_EN
      max_depth_q <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      sp_ld_q     <= 1'b0;
      sp_incr_q   <= 1'b0;
      sp_decr_q   <= 1'b0;
      scr_we_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (REQ_VALID && req_ready_q) begin
            req_ready_q <= 1'b0;
            case (op_e'(REQ_OP))
              OP_PUSH: begin
                if (full_c) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state_q     <= S_RESP;
                end else begin
                  // Push writes below the current SP (SP grows downward, wraps at 0).
                  scr_addr_q  <= SP_IN - ADDR_W'(1);
                  scr_we_q    <= 1'b1;
                  scr_wdata_q <= REQ_DATA;
                  sp_decr_q   <= 1'b1;
                  state_q     <= S_PUSH;
                end
              end
              OP_POP: begin
                if (empty_c) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                  state_q     <= S_RESP;
                end else begin
                  scr_addr_q <= SP_IN;
                  state_q    <= S_POP_RD;
                end
              end
              OP_LOAD: begin
                sp_ld_q   <= 1'b1;
                sp_data_q <= REQ_DATA[ADDR_W-1:0];
                state_q   <= S_LOAD;
              end
              default: begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
                rsp_data_q  <= '0;
                state_q     <= S_RESP;
              end
            endcase
          end
        end

        S_PUSH: begin
          depth_q <= depth_inc_c;
`ifdef STACK_WATERMARK_EN
          if (depth_inc_c > max_depth_q) begin
            max_depth_q <= depth_inc_c;
          end
`endif
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
          state_q     <= S_RESP;
        end

        S_POP_RD: begin
          sp_incr_q <= 1'b1;
          state_q   <= S_POP_CAP;
        end

        // Registered RAM data for the POP_RD address is present this cycle.
        S_POP_CAP: begin
          rsp_data_q  <= SCR_RDATA;
          depth_q     <= depth_dec_c;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end

        S_LOAD: begin
          depth_q     <= '0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= '0;
          state_q     <= S_RESP;
        end

        S_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign REQ_READY   = req_ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_DATA    = rsp_data_q;
  assign RSP_ERR     = rsp_err_q;
  assign SP_LD       = sp_ld_q;
  assign SP_INCR     = sp_incr_q;
  assign SP_DECR     = sp_decr_q;
  assign SP_DATA_OUT = sp_data_q;
  assign SCR_ADDR    = scr_addr_q;
  assign SCR_WE      = scr_we_q;
  assign SCR_WDATA   = scr_wdata_q;
  assign DEPTH       = depth_q;
  assign FULL        = full_c;
  assign EMPTY       = empty_c;
`ifdef STACK_WATERMARK_EN
  assign MAX_DEPTH   = max_depth_q;
`endif

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Directed bench for stack_access_ctrl with a stack-pointer register and registered scratch RAM around it.
module tb_stack_access_ctrl;

  localparam int unsigned DW = 10;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [1:0]    req_op;
  logic [DW-1:0] req_data;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic [AW-1:0] sp_in;
  logic          sp_ld;
  logic          sp_incr;
  logic          sp_decr;
  logic [AW-1:0] sp_dout;
  logic [AW-1:0] scr_addr;
  logic          scr_we;
  logic [DW-1:0] scr_wdata;
  logic [DW-1:0] scr_rdata;
  logic [AW:0]   depth;
  logic          full;
  logic          empty;
`ifdef STACK_WATERMARK_EN
  logic [AW:0]   max_depth;
`endif

  stack_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(clk), .RST(rst),
    .REQ_VALID(req_valid), .REQ_OP(req_op), .REQ_DATA(req_data), .REQ_READY(req_ready),
    .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .RSP_ERR(rsp_err),
    .SP_IN(sp_in), .SP_LD(sp_ld), .SP_INCR(sp_incr), .SP_DECR(sp_decr), .SP_DATA_OUT(sp_dout),
    .SCR_ADDR(scr_addr), .SCR_WE(scr_we), .SCR_WDATA(scr_wdata), .SCR_RDATA(scr_rdata),
    .DEPTH(depth), .FULL(full), .EMPTY(empty)
`ifdef STACK_WATERMARK_EN
    , .MAX_DEPTH(max_depth)
`endif
  );

  always #5 clk = ~clk;

  // Stack pointer register and scratch RAM surrounding the sequencer.
  logic [AW-1:0] sp_q;
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          sp_q <= '0;
    else if (sp_ld)   sp_q <= sp_dout;
    else if (sp_incr) sp_q <= sp_q + AW'(1);
    else if (sp_decr) sp_q <= sp_q - AW'(1);
  end

  always_ff @(posedge clk) begin
    if (scr_we) mem[scr_addr] <= scr_wdata;
    rdata_q <= mem[scr_addr];
  end

  assign sp_in     = sp_q;
  assign scr_rdata = rdata_q;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Per-operation observations.
  int            r_lat, r_we, r_incr, r_decr, r_ld, r_ovl;
  logic          r_err, r_rdy;
  logic [DW-1:0] r_data;
  logic [AW-1:0] r_addr_we, r_addr1, r_spd;

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [DW-1:0] data);
    wait_ready();
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(posedge clk); #1;
    req_valid = 1'b0;
    r_lat = 1; r_we = 0; r_incr = 0; r_decr = 0; r_ld = 0; r_ovl = 0;
    r_addr1 = scr_addr; r_rdy = req_ready; r_addr_we = '0; r_spd = '0;
    while (1) begin
      if (scr_we) begin r_we++; r_addr_we = scr_addr; end
      if (sp_incr) r_incr++;
      if (sp_decr) r_decr++;
      if (sp_ld) begin r_ld++; r_spd = sp_dout; end
      if (int'(sp_ld) + int'(sp_incr) + int'(sp_decr) > 1) r_ovl++;
      if (rsp_valid) break;
      if (r_lat >= 10) begin
        check("rsp_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #1;
      r_lat++;
    end
    r_err  = rsp_err;
    r_data = rsp_data;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int errs;
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_scr_addr", 32'(scr_addr), 32'd0);

    // Push at SP=0 wraps the write address to 0xFF.
    issue(2'b00, 10'h2A5);
    check("push1_lat", 32'(r_lat), 32'd2);
    check("push1_err", 32'(r_err), 32'd0);
    check("push1_we", 32'(r_we), 32'd1);
    check("push1_addr", 32'(r_addr_we), 32'hFF);
    check("push1_decr", 32'(r_decr), 32'd1);
    check("push1_incr", 32'(r_incr + r_ld), 32'd0);
    check("push1_busy", 32'(r_rdy), 32'd0);
    check("push1_depth", 32'(depth), 32'd1);
    check("push1_empty", 32'(empty), 32'd0);

    issue(2'b00, 10'h155);
    check("push2_addr", 32'(r_addr_we), 32'hFE);
    check("push2_depth", 32'(depth), 32'd2);

    issue(2'b01, '0);
    check("pop1_addr", 32'(r_addr1), 32'hFE);
    check("pop1_lat", 32'(r_lat), 32'd3);
    check("pop1_incr", 32'(r_incr), 32'd1);
    check("pop1_other", 32'(r_decr + r_ld + r_we), 32'd0);
    check("pop1_data", 32'(r_data), 32'h155);
    check("pop1_err", 32'(r_err), 32'd0);
    check("pop1_depth", 32'(depth), 32'd1);

    issue(2'b01, '0);
    check("pop2_addr", 32'(r_addr1), 32'hFF);
    check("pop2_data", 32'(r_data), 32'h2A5);
    check("pop2_depth", 32'(depth), 32'd0);
    check("pop2_empty", 32'(empty), 32'd1);
    check("pop2_sp", 32'(sp_in), 32'd0);

    // Underflow.
    issue(2'b01, '0);
    check("uflow_lat", 32'(r_lat), 32'd1);
    check("uflow_err", 32'(r_err), 32'd1);
    check("uflow_strobes", 32'(r_we + r_incr + r_decr + r_ld), 32'd0);
    check("uflow_data", 32'(r_data), 32'd0);
    check("uflow_depth", 32'(depth), 32'd0);

    // Fill to capacity, then overflow.
    do_reset();
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      issue(2'b00, DW'(i));
      if (r_err) errs++;
      if (i == 254) check("fill_not_full", 32'(full), 32'd0);
    end
    check("fill_errs", 32'(errs), 32'd0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_depth", 32'(depth), 32'd256);
    issue(2'b00, 10'h3FF);
    check("oflow_lat", 32'(r_lat), 32'd1);
    check("oflow_err", 32'(r_err), 32'd1);
    check("oflow_strobes", 32'(r_we + r_decr), 32'd0);
    check("oflow_depth", 32'(depth), 32'd256);
    issue(2'b01, '0);
    check("full_pop_data", 32'(r_data), 32'h0FF);
    check("full_pop_depth", 32'(depth), 32'd255);

    // Load SP after three pushes, then the reserved op.
    do_reset();
    for (int i = 0; i < 3; i++) issue(2'b00, DW'(i + 1));
    check("pre_load_depth", 32'(depth), 32'd3);
    issue(2'b10, 10'h080);
    check("load_lat", 32'(r_lat), 32'd2);
    check("load_ld", 32'(r_ld), 32'd1);
    check("load_val", 32'(r_spd), 32'h80);
    check("load_other", 32'(r_incr + r_decr + r_we + r_ovl), 32'd0);
    check("load_err", 32'(r_err), 32'd0);
    check("load_depth", 32'(depth), 32'd0);
    check("load_sp", 32'(sp_in), 32'h80);
    issue(2'b11, 10'h1FF);
    check("rsvd_lat", 32'(r_lat), 32'd1);
    check("rsvd_err", 32'(r_err), 32'd1);
    check("rsvd_strobes", 32'(r_we + r_incr + r_decr + r_ld), 32'd0);

    // Reset during POP_CAP abandons the pop.
    do_reset();
    issue(2'b00, 10'h03C);
    wait_ready();
    req_valid = 1'b1; req_op = 2'b01; req_data = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_rd_addr", 32'(scr_addr), 32'hFF);
    @(posedge clk); #1;
    check("abort_cap_incr", 32'(sp_incr), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_incr", 32'(sp_incr), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_empty", 32'(empty), 32'd1);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_addr", 32'(scr_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    issue(2'b01, '0);
    check("abort_pop_err", 32'(r_err), 32'd1);
    check("abort_pop_lat", 32'(r_lat), 32'd1);

`ifdef STACK_WATERMARK_EN
    do_reset();
    check("wm_rst", 32'(max_depth), 32'd0);
    for (int i = 0; i < 5; i++) issue(2'b00, DW'(i));
    issue(2'b01, '0);
    issue(2'b01, '0);
    issue(2'b00, 10'h011);
    check("wm_max", 32'(max_depth), 32'd5);
    check("wm_depth", 32'(depth), 32'd4);
    issue(2'b10, 10'h010);
    check("wm_after_load", 32'(max_depth), 32'd5);
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
